// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves RISC-V conditional branches in EX from the ALU flags of a - b,
// checks the result against the fetch-time prediction, trains a 2-bit
// counter branch history table, and issues a registered one-cycle PC
// redirect on misprediction or jump. Keeps saturating resolution and
// misprediction counters.
//
// Ports
//   clk, rst_n        clock / async active-low reset
//   f_pc              fetch PC for prediction lookup
//   f_pred_taken      combinational prediction (MSB of BHT entry)
//   ex_valid          EX holds a conditional branch
//   ex_jump           EX holds JAL/JALR (wins over ex_valid)
//   ex_funct3         branch condition select
//   ex_pc, ex_target  EX instruction PC and computed target
//   ex_pred_taken     prediction carried with the instruction
//   cf, zf, vf, sf    ALU flags of a - b
//   stall             EX contents not consumed this cycle
//   redirect          registered redirect strobe
//   redirect_pc       registered redirect target
//   br_count          resolved conditional branches (saturating)
//   mispred_count     conditional mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] f_pc,
   output logic        f_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_jump,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic        cf,
   input  logic        zf,
   input  logic        vf,
   input  logic        sf,
   input  logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int N_ENT = 1 << IDX_W;

   logic [1:0]       r_bht [N_ENT];
   logic             r_redirect;
   logic [31:0]      r_redirect_pc;
   logic [31:0]      r_br_count;
   logic [31:0]      r_mispred_count;

   logic [IDX_W-1:0] w_f_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_taken;
   logic             w_legal;
   logic             w_f_pc_unused;

   assign w_f_idx       = f_pc[IDX_W+1:2];
   assign w_ex_idx      = ex_pc[IDX_W+1:2];
   assign w_f_pc_unused = ^{f_pc[31:IDX_W+2], f_pc[1:0]};
   assign f_pred_taken  = r_bht[w_f_idx][1];

   always_comb begin
      w_taken = 1'b0;
      w_legal = 1'b1;
      case (ex_funct3)
         3'b000:  w_taken = zf;
         3'b001:  w_taken = ~zf;
         3'b100:  w_taken = sf ^ vf;
         3'b101:  w_taken = ~(sf ^ vf);
         3'b110:  w_taken = ~cf;
         3'b111:  w_taken = cf;
         default: w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect      <= 1'b0;
         r_redirect_pc   <= '0;
         r_br_count      <= '0;
         r_mispred_count <= '0;
         for (int i = 0; i < N_ENT; i++) r_bht[i] <= 2'b01;
      end else if (!stall) begin
         if (r_redirect) begin
            // instruction in EX is wrong-path: drop it
            r_redirect <= 1'b0;
         end else if (ex_jump) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= ex_target;
         end else if (ex_valid && w_legal) begin
            if (r_br_count != 32'hFFFF_FFFF) r_br_count <= r_br_count + 32'd1;
            if (w_taken && r_bht[w_ex_idx] != 2'b11)
               r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
            else if (!w_taken && r_bht[w_ex_idx] != 2'b00)
               r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
            if (w_taken != ex_pred_taken) begin
               r_redirect    <= 1'b1;
               r_redirect_pc <= w_taken ? ex_target : ex_pc + 32'd4;
               if (r_mispred_count != 32'hFFFF_FFFF)
                  r_mispred_count <= r_mispred_count + 32'd1;
            end else begin
               r_redirect <= 1'b0;
            end
         end else begin
            r_redirect <= 1'b0;
         end
      end
   end

   assign redirect      = r_redirect;
   assign redirect_pc   = r_redirect_pc;
   assign br_count      = r_br_count;
   assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic        ex_valid, ex_jump, ex_pred_taken;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_target;
   logic        cf, zf, vf, sf, stall;
   logic        redirect;
   logic [31:0] redirect_pc, br_count, mispred_count;

   always #5 clk = ~clk;

   branch_resolve_unit #(.IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .cf(cf), .zf(zf), .vf(vf), .sf(sf), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference state
   int          m_bht [16];
   logic        m_redirect;
   logic [31:0] m_rpc, m_br, m_mis;
   logic [31:0] cur_a, cur_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // branch outcome straight from the operands, not from the flags
   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_redirect = 0; m_rpc = 0; m_br = 0; m_mis = 0;
   endtask

   task automatic drive(input logic v, input logic j, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic stl);
      logic [32:0] sum;
      logic [31:0] diff;
      sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      diff = sum[31:0];
      ex_valid = v; ex_jump = j; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
      ex_pred_taken = pred; stall = stl;
      cf = sum[32]; zf = (diff == 32'd0); sf = diff[31];
      vf = (a[31] ^ b[31]) & (diff[31] ^ a[31]);
      cur_a = a; cur_b = b;
   endtask

   task automatic idle();
      drive(0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
   endtask

   // advance one clock: model the edge, then compare all registered outputs
   task automatic step();
      logic tk;
      int   idx;
      #1;
      chk("f_pred_pre", {31'd0, f_pred_taken}, {31'd0, m_bht[f_pc[5:2]] >= 2});
      if (!stall) begin
         if (m_redirect) m_redirect = 0;
         else if (ex_jump) begin m_redirect = 1; m_rpc = ex_target; end
         else if (ex_valid && ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
            tk  = ref_taken(ex_funct3, cur_a, cur_b);
            idx = int'(ex_pc[5:2]);
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            if (tk != ex_pred_taken) begin
               m_redirect = 1;
               m_rpc = tk ? ex_target : ex_pc + 32'd4;
               if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            end else m_redirect = 0;
         end else m_redirect = 0;
      end
      @(posedge clk);
      #1;
      chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("br_count", br_count, m_br);
      chk("mispred_count", mispred_count, m_mis);
   endtask

   initial begin
      rst_n = 0;
      f_pc  = 0;
      model_reset();
      drive(1, 1, 3'd0, $urandom, $urandom, $urandom, $urandom, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_br_count", br_count, 32'd0);
      chk("rst_mispred", mispred_count, 32'd0);
      for (int i = 0; i < 16; i++) begin
         f_pc = 32'(i) << 2; #1;
         chk("rst_f_pred", {31'd0, f_pred_taken}, 32'd0);
      end
      idle();
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         f_pc = 32'(i) << 2; #1;
         chk("post_rst_f_pred", {31'd0, f_pred_taken}, 32'd0);
      end
      @(posedge clk); #1;

      // BEQ predicted not-taken, equal operands
      f_pc = 32'h100;
      drive(1, 0, 3'd0, 32'd7, 32'd7, 32'h100, 32'h180, 0, 0); step();
      chk("beq_rpc", redirect_pc, 32'h180);
      chk("beq_redirect", {31'd0, redirect}, 32'd1);
      idle(); step();
      chk("beq_bht_trained", {31'd0, f_pred_taken}, 32'd1);

      // BLTU 1<2 predicted taken: correct; then BGEU wraps to 0
      drive(1, 0, 3'd6, 32'd1, 32'd2, 32'h204, 32'h300, 1, 0); step();
      drive(1, 0, 3'd7, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h500, 1, 0); step();
      chk("bgeu_wrap_rpc", redirect_pc, 32'h0);
      idle(); step();

      // signed: a=0x7FFFFFFF, b=-1 -> overflow, sf=1 vf=1; use a=-2^31+..: pick sf=0,vf=1
      drive(1, 0, 3'd4, 32'h8000_0000, 32'd1, 32'h40, 32'h60, 0, 0); step();
      chk("blt_ovf_taken", redirect_pc, 32'h60);
      idle(); step();
      drive(1, 0, 3'd5, 32'h8000_0000, 32'd1, 32'h40, 32'h60, 1, 0); step();
      chk("bge_ovf_nt", redirect_pc, 32'h44);
      idle(); step();

      // saturation: 4 taken then 1 not-taken at index 3
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 3'd1, 32'd1, 32'd2, 32'h0C, 32'h80, 1, 0); step();
      end
      drive(1, 0, 3'd0, 32'd1, 32'd2, 32'h0C, 32'h80, 0, 0); step();
      f_pc = 32'h0C; #1;
      chk("sat_still_taken", {31'd0, f_pred_taken}, 32'd1);

      // jump then masked mispredicting BNE, then illegal funct3
      drive(0, 1, 3'd0, 32'd0, 32'd0, 32'h20, 32'h400, 0, 0); step();
      drive(1, 0, 3'd1, 32'd1, 32'd2, 32'h24, 32'h900, 0, 0); step();
      chk("mask_redirect", {31'd0, redirect}, 32'd0);
      chk("mask_rpc", redirect_pc, 32'h400);
      drive(1, 0, 3'd2, 32'd1, 32'd2, 32'h28, 32'h900, 1, 0); step();
      idle(); step();

      // stall hold, then async reset mid-hold
      drive(1, 0, 3'd0, 32'd5, 32'd5, 32'h30, 32'h700, 0, 0); step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 3'd1, 32'd1, 32'd2, 32'h34, 32'h900, 0, 1); step();
      end
      chk("stall_hold", {31'd0, redirect}, 32'd1);
      #2 rst_n = 0; #1;
      model_reset();
      chk("async_rst_redirect", {31'd0, redirect}, 32'd0);
      chk("async_rst_br", br_count, 32'd0);
      chk("async_rst_mis", mispred_count, 32'd0);
      idle();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
         f_pc = {24'd0, 4'($urandom), 2'b00};
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, f3, a, b,
               {$urandom_range(0, 255), 2'b00} | {$urandom_range(0, 1) ? 32'hFFFF_FC00 : 32'd0},
               {$urandom, 2'b00}, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumer side of the ALU flag interface: takes the carry/zero/overflow/sign flags produced by the EX-stage subtraction for a conditional branch, resolves the RISC-V branch condition, and compares it to the direction predicted at fetch. It owns a 2-bit-counter branch history table (BHT) that supplies fetch-stage predictions and is trained at resolution. It issues a registered one-cycle PC redirect on misprediction or jump, and keeps resolution/misprediction statistics.

## Interface
- IDX_W, 4, BHT index width; table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2]
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_pc  in  32  fetch-stage PC for prediction lookup
- f_pred_taken  out  1  combinational: MSB of BHT[f_pc index]
- ex_valid  in  1  EX holds a conditional branch
- ex_jump  in  1  EX holds JAL/JALR
- ex_funct3  in  3  branch funct3
- ex_pc  in  32  PC of EX instruction
- ex_target  in  32  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- cf, zf, vf, sf  in  1 each  ALU flags from a − b (cf = carry out of a + ~b + 1)
- stall  in  1  pipeline stall; EX contents not to be consumed this cycle
- redirect  out  1  registered; fetch must load redirect_pc, IF/ID and ID/EX flushed
- redirect_pc  out  32  registered redirect target
- br_count  out  32  resolved conditional branches, saturating
- mispred_count  out  32  conditional mispredictions, saturating

## Operation
- Condition (taken): 000 BEQ zf; 001 BNE ~zf; 100 BLT sf^vf; 101 BGE ~(sf^vf); 110 BLTU ~cf; 111 BGEU cf. funct3 010/011 illegal: not taken, no BHT update, no count, no redirect.
- Accept: EX instruction consumed on an edge when stall=0 and mask=0, where mask = redirect (EX holds wrong-path instruction while redirect is high).
- Jump (ex_jump=1; wins if ex_valid also 1): redirect=1, redirect_pc=ex_target; no BHT update; no counts.
- Conditional branch, legal funct3: br_count+1; BHT[ex_pc index] += 1 if taken (saturate at 3), −1 if not (saturate at 0). If taken != ex_pred_taken: redirect=1, redirect_pc = taken ? ex_target : ex_pc+4 (mod 2^32), mispred_count+1.
- Otherwise redirect=0 next cycle; redirect_pc holds its last value.
- Counters saturate at 0xFFFF_FFFF, never wrap.
- Same-index read/write in one cycle: f_pred_taken reflects pre-edge value; new value visible the cycle after.

## Timing
- Reset (async, rst_n=0): redirect=0, redirect_pc=0, br_count=0, mispred_count=0, all BHT entries 2'b01 (weakly not-taken) so f_pred_taken=0. Reset asserted mid-redirect clears it immediately, without waiting for clk.
- Latency: branch accepted at edge N -> redirect/redirect_pc valid during cycle N..N+1, one cycle, unless stalled.
- stall=1 while redirect=1: redirect and redirect_pc held; cleared on first edge with stall=0 (that edge consumes nothing, mask applies).
- Back-to-back: redirect is never high two consecutive unstalled cycles, because the instruction following a redirecting one is always masked.
- f_pred_taken is purely combinational from f_pc and BHT; no other output is combinational.

## Test plan
- Reset: hold rst_n=0, drive all inputs -> all outputs 0, f_pred_taken=0 for every f_pc; release, sample all 16 entries still 01.
- BEQ predicted not-taken, zf=1, ex_pc=0x100, target=0x180 -> next cycle redirect=1, redirect_pc=0x180, br_count=1, mispred_count=1; f_pc=0x100 then gives f_pred_taken=1.
- BLTU a=1,b=2 (cf=0) with ex_pred_taken=1 -> taken, no redirect, br_count+1; BGEU same flags, pred 1, ex_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000.
- Signed: BLT with sf=0,vf=1 (overflowed negative) -> taken; BGE same flags -> not taken; counter saturation checked by 4 taken then 1 not-taken at one index -> entry 2 (still predicts taken).
- Jump + mask: JAL target 0x400 accepted, next cycle mispredicting BNE presented -> only one redirect (0x400), BNE ignored, counts unchanged; illegal funct3 010 -> no effect.
- Stall/reset interplay: redirect raised, stall=1 three cycles -> redirect held; drop rst_n mid-hold -> redirect falls asynchronously, counters 0.
